mul_fsm: RTL

//  Multi-cycle IEEE-754 single-precision multiplier; companion of the divider FSM in the FP unit.

---
 rtl/mul_fsm.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_fsm.sv
// mul_fsm: multi-cycle IEEE-754 binary32 multiplier.
//   Shares the r_i/r_o handshake and operand naming with the divider FSM, so
//   both can sit behind the same FP dispatch logic. The mantissa product is
//   built with a radix-2 shift-add loop (one partial product per clock). The
//   result is rounded to nearest-even, and denormal inputs and outputs are
//   flushed to zero.
//   Latency is fixed: capture edge E0, r_o high from E26 to E27.
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-high reset
//   n, x  operands A and B (binary32)
//   r_i   request, sampled only in IDLE
//   busy  high from the capture edge until r_o falls
//   res   product n*x, valid with r_o, held until the next result
//   r_o   one-cycle result-valid pulse
module mul_fsm #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] n,
  input  logic [31:0] x,
  input  logic        r_i,
  output logic        busy,
  output logic [31:0] res,
  output logic        r_o
);

  localparam int FW  = MANT_W - 1;         // stored fraction width
  localparam int PW  = 2 * MANT_W;         // product width
  localparam int CW  = $clog2(MANT_W);     // loop counter width
  localparam int XW  = EXP_W + 2;          // signed working exponent width
  localparam logic [CW-1:0]        LAST_CNT = CW'(MANT_W - 1);
  localparam logic signed [XW-1:0] BIAS_S   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [31:0]          QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, MUL, NORM, PACK} state_t;

  // Operand class is resolved once at capture. The loop still runs, and PACK
  // picks the override.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } spec_t;

  state_t state_q, state_d;

  logic              capture, mul_step, norm_en, pack_en;
  logic              sign_q;
  logic [MANT_W-1:0] a_q, b_q;
  logic [PW-1:0]     p_q;
  logic [CW-1:0]     cnt_q;
  logic signed [XW-1:0] exp_q;
  logic [FW-1:0]     mant_q;
  spec_t             spec_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    mul_step = 1'b0;
    norm_en  = 1'b0;
    pack_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (r_i) begin
          capture = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (cnt_q == LAST_CNT) state_d = NORM;
      end
      NORM: begin
        norm_en = 1'b1;
        state_d = PACK;
      end
      PACK: begin
        // Returning to IDLE here lets a held r_i recapture on the very edge
        // that drops r_o, so back-to-back results come out 27 clocks apart.
        pack_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand decode at capture
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] ea, eb;
  logic [FW-1:0]    fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  spec_t            spec_d;
  logic signed [XW-1:0] exp_sum;

  always_comb begin
    ea     = n[FW +: EXP_W];
    eb     = x[FW +: EXP_W];
    fa     = n[FW-1:0];
    fb     = x[FW-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    spec_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    spec_d.inf  = (a_inf | b_inf) & ~spec_d.nan;
    spec_d.zero = (a_zero | b_zero) & ~spec_d.nan & ~spec_d.inf;
    // Finite range is -125..381, plus at most two increments, so the 10-bit
    // signed exponent never wraps.
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
  end

  // ---------------------------------------------------------------------------
  // Normalise and round (consumed in NORM)
  // ---------------------------------------------------------------------------
  logic              hi, g_bit, s_bit, inc, carry;
  logic [FW-1:0]     m_pre;
  logic [MANT_W-1:0] m_sum;
  logic signed [XW-1:0] exp_n;

  always_comb begin
    hi    = p_q[PW-1];
    m_pre = hi ? p_q[PW-2 -: FW] : p_q[PW-3 -: FW];
    g_bit = hi ? p_q[MANT_W-1] : p_q[MANT_W-2];
    s_bit = hi ? (|p_q[MANT_W-2:0]) : (|p_q[MANT_W-3:0]);
    inc   = g_bit & (s_bit | m_pre[0]);
    m_sum = {1'b0, m_pre} + MANT_W'(inc);
    // A rounding carry-out leaves the fraction field at all zeros.
    carry = m_sum[MANT_W-1];
    exp_n = exp_q + $signed({{(XW-1){1'b0}}, hi}) + $signed({{(XW-1){1'b0}}, carry});
  end

  // ---------------------------------------------------------------------------
  // Final result selection (consumed in PACK)
  // ---------------------------------------------------------------------------
  logic [31:0] res_d;

  always_comb begin
    if (spec_q.nan)               res_d = QNAN;
    else if (spec_q.inf)          res_d = {sign_q, EXP_ONES, {FW{1'b0}}};
    else if (spec_q.zero)         res_d = {sign_q, 31'h0};
    else if (exp_q >= EXP_MAX)    res_d = {sign_q, EXP_ONES, {FW{1'b0}}};
    else if (exp_q <= $signed(XW'(0))) res_d = {sign_q, 31'h0};
    else                          res_d = {sign_q, exp_q[EXP_W-1:0], mant_q};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
      mant_q <= '0;
      spec_q <= '0;
      busy   <= 1'b0;
      res    <= 32'h0;
      r_o    <= 1'b0;
    end else begin
      r_o <= pack_en;
      // Capture wins over the release, so a held r_i keeps busy high.
      if (capture)  busy <= 1'b1;
      else if (r_o) busy <= 1'b0;

      if (capture) begin
        sign_q <= n[31] ^ x[31];
        a_q    <= {1'b1, fa};
        b_q    <= {1'b1, fb};
        p_q    <= '0;
        cnt_q  <= '0;
        exp_q  <= exp_sum;
        spec_q <= spec_d;
      end

      if (mul_step) begin
        if (b_q[cnt_q]) p_q <= p_q + ({{MANT_W{1'b0}}, a_q} << cnt_q);
        cnt_q <= cnt_q + 1'b1;
      end

      if (norm_en) begin
        mant_q <= m_sum[FW-1:0];
        exp_q  <= exp_n;
      end

      if (pack_en) res <= res_d;
    end
  end

endmodule
